// File: rtl/button_conditioner.sv
// Button front end: 2-FF sync, debounce, press pulses, frame-aligned step accumulator.
// Define AUTOREPEAT_EN to add per-button hold-to-repeat stepping after REPEAT_DELAY ticks.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACC_W           = 4,
  parameter int REPEAT_DELAY    = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_right,
  input  logic             btn_left,
  input  logic             vsync,
  output logic             frame_tick,
  output logic [3:0]       btn_level,
  output logic [3:0]       press_pulse,
  output logic [ACC_W-1:0] accum
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [ACC_W-1:0] STEP1 = ACC_W'(1);
  localparam logic [ACC_W-1:0] STEP4 = ACC_W'(4);

  logic [3:0]       raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       accept;
  logic [3:0]       pend;
  logic [3:0]       rep;
  logic [3:0]       eff;
  logic [CW-1:0]    cnt [4];
  logic             vsync_prev;
  logic [ACC_W-1:0] delta;

  assign raw = {btn_left, btn_right, btn_down, btn_up};

  // A change is accepted on its DEBOUNCE_CYCLES-th consecutive differing sample
  always_comb begin
    accept = '0;
    for (int i = 0; i < 4; i++) begin
      accept[i] = (sync2[i] != btn_level[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      btn_level   <= '0;
      press_pulse <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      press_pulse <= accept & sync2;
      for (int i = 0; i < 4; i++) begin
        if (accept[i]) begin
          btn_level[i] <= sync2[i];
          cnt[i]       <= '0;
        end else if (sync2[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam logic [HW-1:0] RD       = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  logic [HW-1:0] hold     [4];
  logic [HW-1:0] hold_nxt [4];

  // Repeat is judged on the post-increment count of this tick
  always_comb begin
    rep = '0;
    for (int i = 0; i < 4; i++) begin
      hold_nxt[i] = (hold[i] == RD) ? hold[i] : hold[i] + HOLD_ONE;
      rep[i]      = btn_level[i] && (hold_nxt[i] == RD);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!btn_level[i]) begin
          hold[i] <= '0;
        end else if (frame_tick) begin
          hold[i] <= hold_nxt[i];
        end
      end
    end
  end
`else
  assign rep = '0;
`endif

  assign eff = pend | press_pulse | rep;

  always_comb begin
    delta = '0;
    if (eff[0]) delta = delta + STEP1;
    if (eff[1]) delta = delta - STEP1;
    if (eff[2]) delta = delta + STEP4;
    if (eff[3]) delta = delta - STEP4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev <= 1'b1;
      frame_tick <= 1'b0;
      pend       <= '0;
      accum      <= '0;
    end else begin
      vsync_prev <= vsync;
      frame_tick <= vsync & ~vsync_prev;
      if (frame_tick) begin
        accum <= accum + delta;
        pend  <= '0;
      end else begin
        pend <= pend | press_pulse;
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: vector table, directed corners,
// and random stimulus against a history-based reference model.
module tb_button_conditioner;

  localparam int DC = 4;
  localparam int AW = 4;
  localparam int RD = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    btns = '0;
  logic          vsync = 1'b1;
  logic          frame_tick;
  logic [3:0]    btn_level;
  logic [3:0]    press_pulse;
  logic [AW-1:0] accum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .ACC_W(AW),
    .REPEAT_DELAY(RD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btns[0]),
    .btn_down(btns[1]),
    .btn_right(btns[2]),
    .btn_left(btns[3]),
    .vsync(vsync),
    .frame_tick(frame_tick),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .accum(accum)
  );

  // Reference model: raw samples delayed two edges, a level flips once the
  // last DC delayed samples all disagree with it.
  logic [3:0] q_raw [$];
  logic [3:0] hist [$];
  logic [3:0] m_lvl, m_pp, m_pend;
  logic       m_ft, m_vprev;
  int         m_acc;
  int         m_hold [4];

  task automatic model_step(input logic r, input logic [3:0] b, input logic v);
    logic [3:0] x, old_lvl, old_pp, new_lvl, rep, eff;
    logic old_ft, all_diff;
    int d;
    if (r) begin
      q_raw = {4'b0, 4'b0};
      hist.delete();
      m_lvl = '0; m_pp = '0; m_pend = '0;
      m_ft = 1'b0; m_vprev = 1'b1; m_acc = 0;
      for (int i = 0; i < 4; i++) m_hold[i] = 0;
      return;
    end
    x = q_raw.pop_front();
    q_raw.push_back(b);
    hist.push_back(x);
    if (hist.size() > DC) void'(hist.pop_front());
    old_lvl = m_lvl; old_pp = m_pp; old_ft = m_ft;
    new_lvl = old_lvl;
    for (int i = 0; i < 4; i++) begin
      if (hist.size() == DC) begin
        all_diff = 1'b1;
        foreach (hist[j]) if (hist[j][i] == old_lvl[i]) all_diff = 1'b0;
        if (all_diff) new_lvl[i] = ~old_lvl[i];
      end
    end
    rep = '0;
`ifdef AUTOREPEAT_EN
    for (int i = 0; i < 4; i++) begin
      if (!old_lvl[i]) m_hold[i] = 0;
      else if (old_ft) begin
        if (m_hold[i] < RD) m_hold[i]++;
        rep[i] = (m_hold[i] == RD);
      end
    end
`endif
    if (old_ft) begin
      eff = m_pend | old_pp | rep;
      d = int'(eff[0]) - int'(eff[1]) + 4 * int'(eff[2]) - 4 * int'(eff[3]);
      m_acc = (((m_acc + d) % 16) + 16) % 16;
      m_pend = '0;
    end else begin
      m_pend = m_pend | old_pp;
    end
    m_pp = new_lvl & ~old_lvl;
    m_lvl = new_lvl;
    m_ft = v & ~m_vprev;
    m_vprev = v;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(rst, btns, vsync);
    #1;
    check("model", {19'b0, frame_tick, btn_level, press_pulse, accum},
          {19'b0, m_ft, m_lvl, m_pp, 4'(m_acc)});
  endtask

  task automatic wait_n(input int n);
    repeat (n) cyc();
  endtask

  task automatic press(input logic [3:0] m);
    btns = m; wait_n(DC + 4);
    btns = '0; wait_n(DC + 4);
  endtask

  task automatic frame();
    vsync = 1'b0; wait_n(2);
    vsync = 1'b1; wait_n(3);
  endtask

  task automatic do_reset();
    rst = 1'b1; btns = '0; vsync = 1'b1; wait_n(2);
    rst = 1'b0; wait_n(1);
  endtask

  typedef struct {
    logic       r;
    logic       v;
    logic [3:0] b;
    logic       e_ft;
    logic [3:0] e_lvl;
    logic [3:0] e_pp;
    logic [3:0] e_acc;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic r, logic v, logic [3:0] b, logic ft,
                              logic [3:0] lvl, logic [3:0] pp);
    vec_t t;
    t.r = r; t.v = v; t.b = b; t.e_ft = ft;
    t.e_lvl = lvl; t.e_pp = pp; t.e_acc = '0;
    return t;
  endfunction

  initial begin
    int vcnt;
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 1, 0, 0, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 0, 1, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0));

    foreach (tbl[k]) begin
      rst = tbl[k].r; vsync = tbl[k].v; btns = tbl[k].b;
      cyc();
      check($sformatf("vec%0d_tick", k), {31'b0, frame_tick}, {31'b0, tbl[k].e_ft});
      check($sformatf("vec%0d_level", k), {28'b0, btn_level}, {28'b0, tbl[k].e_lvl});
      check($sformatf("vec%0d_pulse", k), {28'b0, press_pulse}, {28'b0, tbl[k].e_pp});
      check($sformatf("vec%0d_accum", k), {28'b0, accum}, {28'b0, tbl[k].e_acc});
    end

    do_reset();
    press(4'b0100); frame();
    check("right_once", 32'(accum), 32'd4);
    btns = 4'b0100; wait_n(DC + 4);
    frame(); check("right_held_t1", 32'(accum), 32'd8);
    frame(); check("right_held_t2", 32'(accum), 32'd8);
    frame();
`ifdef AUTOREPEAT_EN
    check("right_held_t3", 32'(accum), 32'd12);
`else
    check("right_held_t3", 32'(accum), 32'd8);
`endif
    btns = '0; wait_n(DC + 4);

    do_reset();
    press(4'b1001); frame(); check("up_left", 32'(accum), 32'd13);
    press(4'b0010); frame(); check("down_a", 32'(accum), 32'd12);
    press(4'b0010); frame(); check("down_b", 32'(accum), 32'd11);
    press(4'b0010); press(4'b0010); frame();
    check("down_twice_one_frame", 32'(accum), 32'd10);

    do_reset();
    press(4'b0010); frame(); check("wrap_down", 32'(accum), 32'd15);
    press(4'b0001); frame(); check("wrap_up", 32'(accum), 32'd0);

    do_reset();
    vsync = 1'b0; btns = 4'b0010; wait_n(DC + 1);
    vsync = 1'b1; cyc();
    check("coincident_edge", {27'b0, frame_tick, press_pulse}, {27'b0, 5'b10010});
    cyc(); check("coincident_accum", 32'(accum), 32'd15);
    frame(); check("coincident_next", 32'(accum), 32'd15);
    btns = '0; wait_n(DC + 4);

`ifdef AUTOREPEAT_EN
    do_reset();
    btns = 4'b0001; wait_n(DC + 4);
    for (int t = 0; t < 6; t++) begin
      frame();
      check($sformatf("repeat_t%0d", t), 32'(accum), (t < 2) ? 32'd1 : 32'(t));
    end
    btns = '0; wait_n(DC + 4);
    frame(); check("repeat_release_a", 32'(accum), 32'd5);
    frame(); check("repeat_release_b", 32'(accum), 32'd5);
`endif

    do_reset();
    vcnt = 3;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(7) == 0) btns[$urandom_range(3)] ^= 1'b1;
      if (vcnt == 0) begin
        vsync = ~vsync;
        vcnt = $urandom_range(12, 1);
      end else begin
        vcnt--;
      end
      rst = ($urandom_range(399) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
